// File: rtl/collision_referee_if.sv
// collision_referee_if: ball/paddle geometry in, bounce/speed/score status out
interface collision_referee_if;
    logic       restart;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [7:0] ball_w;
    logic [7:0] ball_h;
    logic [9:0] pad_l_y;
    logic [9:0] pad_r_y;
    logic [1:0] bounce;
    logic [2:0] speed;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       game_over;
    modport master (
        output restart, ball_x, ball_y, ball_w, ball_h, pad_l_y, pad_r_y,
        input  bounce, speed, score_l, score_r, game_over
    );
    modport slave (
        input  restart, ball_x, ball_y, ball_w, ball_h, pad_l_y, pad_r_y,
        output bounce, speed, score_l, score_r, game_over
    );
endinterface

// File: rtl/collision_referee.sv
// collision_referee: ball contact classifier, bounce hold/lockout, scoring; COLLISION_REFEREE_SPEEDUP_EN enables paddle speed-up
module collision_referee #(
    parameter int SCREEN_X   = 640,
    parameter int SCREEN_Y   = 480,
    parameter int PAD_L_X    = 16,
    parameter int PAD_R_X    = 616,
    parameter int PAD_W      = 8,
    parameter int PAD_H      = 64,
    parameter int WIN_SCORE  = 9,
    parameter int SPEED_INIT = 6,
    parameter int SPEED_MIN  = 1
) (
    input logic clock,
    input logic reset,
    collision_referee_if.slave bus
);
    typedef enum logic [1:0] {PLAY, HOLD, LOCKOUT, OVER} state_t;
    typedef enum logic [2:0] {NONE, PAD_L, PAD_R, WALL, MISS_L, MISS_R} cls_t;
    localparam logic [10:0] SX  = 11'(SCREEN_X);
    localparam logic [10:0] SY  = 11'(SCREEN_Y);
    localparam logic [10:0] PLE = 11'(PAD_L_X + PAD_W);
    localparam logic [10:0] PRX = 11'(PAD_R_X);
    localparam logic [10:0] PH  = 11'(PAD_H);
    localparam logic [3:0]  WS  = 4'(WIN_SCORE);
    localparam logic [2:0]  SI  = 3'(SPEED_INIT);
`ifdef COLLISION_REFEREE_SPEEDUP_EN
    localparam logic [2:0]  SM  = 3'(SPEED_MIN);
`endif
    state_t state, state_n;
    cls_t cls, lat_cls, lat_cls_n;
    logic [9:0] lat_x, lat_y, lat_x_n, lat_y_n;
    logic [1:0] bounce, bounce_n;
    logic [2:0] speed, speed_n;
    logic [3:0] score_l, score_r, score_l_n, score_r_n, inc_l, inc_r;
    logic [10:0] bx, by, x_end, y_end, pl, pr;
    logic ov_l, ov_r, is_miss, is_pad, lat_miss, moved;
    assign bx    = {1'b0, bus.ball_x};
    assign by    = {1'b0, bus.ball_y};
    assign pl    = {1'b0, bus.pad_l_y};
    assign pr    = {1'b0, bus.pad_r_y};
    assign x_end = bx + {3'b0, bus.ball_w};
    assign y_end = by + {3'b0, bus.ball_h};
    assign ov_l  = y_end > pl && by < pl + PH;
    assign ov_r  = y_end > pr && by < pr + PH;
    assign cls = bus.ball_x == '0        ? MISS_L :
                 x_end >= SX             ? MISS_R :
                 bx <= PLE && ov_l       ? PAD_L  :
                 x_end >= PRX && ov_r    ? PAD_R  :
                 by == '0 || y_end >= SY ? WALL   : NONE;
    assign is_miss  = cls == MISS_L || cls == MISS_R;
    assign is_pad   = cls == PAD_L || cls == PAD_R;
    assign lat_miss = lat_cls == MISS_L || lat_cls == MISS_R;
    assign moved    = bus.ball_x != lat_x || bus.ball_y != lat_y;
    assign inc_l    = score_l == WS ? score_l : score_l + 4'd1;
    assign inc_r    = score_r == WS ? score_r : score_r + 4'd1;
    always_comb begin
        state_n   = state;
        lat_cls_n = lat_cls;
        lat_x_n   = lat_x;
        lat_y_n   = lat_y;
        bounce_n  = bounce;
        speed_n   = speed;
        score_l_n = score_l;
        score_r_n = score_r;
        if (bus.restart) begin
            state_n   = PLAY;
            bounce_n  = 2'b00;
            speed_n   = SI;
            score_l_n = '0;
            score_r_n = '0;
        end else begin
            case (state)
                PLAY: if (cls != NONE) begin
                    lat_cls_n = cls;
                    lat_x_n   = bus.ball_x;
                    lat_y_n   = bus.ball_y;
                    bounce_n  = is_miss ? 2'b11 : is_pad ? 2'b01 : 2'b10;
                    state_n   = HOLD;
                    if (is_miss) begin
                        score_l_n = cls == MISS_R ? inc_l : score_l;
                        score_r_n = cls == MISS_L ? inc_r : score_r;
                        speed_n   = SI;
                        state_n   = (score_l_n == WS || score_r_n == WS) ? OVER : HOLD;
                    end
`ifdef COLLISION_REFEREE_SPEEDUP_EN
                    if (is_pad) speed_n = speed > SM ? speed - 3'd1 : SM;
`endif
                end
                HOLD: if (moved) begin
                    bounce_n = 2'b00;
                    state_n  = lat_miss ? PLAY : LOCKOUT;
                end
                LOCKOUT: begin
                    bounce_n = 2'b00;
                    state_n  = cls != lat_cls ? PLAY : LOCKOUT;
                end
                OVER: bounce_n = 2'b11;
                default: state_n = PLAY;
            endcase
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= PLAY;
            lat_cls <= NONE;
            lat_x   <= '0;
            lat_y   <= '0;
            bounce  <= 2'b00;
            speed   <= SI;
            score_l <= '0;
            score_r <= '0;
        end else begin
            state   <= state_n;
            lat_cls <= lat_cls_n;
            lat_x   <= lat_x_n;
            lat_y   <= lat_y_n;
            bounce  <= bounce_n;
            speed   <= speed_n;
            score_l <= score_l_n;
            score_r <= score_r_n;
        end
    end
    assign bus.bounce    = bounce;
    assign bus.speed     = speed;
    assign bus.score_l   = score_l;
    assign bus.score_r   = score_r;
    assign bus.game_over = state == OVER;
endmodule

// File: tb/tb_collision_referee.sv
// tb_collision_referee: scripted scoreboard bench for collision_referee
module tb_collision_referee;
    logic clock = 1'b0;
    logic reset;
    collision_referee_if bus();
    collision_referee dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
`ifdef COLLISION_REFEREE_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif
    typedef struct {int b; int sp; int sl; int sr; int go;} exp_t;
    exp_t sb[$];
    int tests = 0, fails = 0, step = 0;
    int sp = 6, sl = 0, sr = 0;
    task automatic check(input string tag, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s @step %0d: got %0d expected %0d", tag, step, got, want);
        end
    endtask
    task automatic place(input int x, input int y);
        bus.ball_x = 10'(x);
        bus.ball_y = 10'(y);
    endtask
    task automatic tick(input int b, input int go = 0);
        exp_t e;
        sb.push_back('{b, sp, sl, sr, go});
        @(posedge clock);
        #1;
        e = sb.pop_front();
        step++;
        check("bounce", int'(bus.bounce), e.b);
        check("speed", int'(bus.speed), e.sp);
        check("score_l", int'(bus.score_l), e.sl);
        check("score_r", int'(bus.score_r), e.sr);
        check("game_over", int'(bus.game_over), e.go);
    endtask
    task automatic pad_hit();
        sp = SPEEDUP ? (sp > 1 ? sp - 1 : 1) : 6;
    endtask
    initial begin
        reset = 1'b1;
        bus.restart = 1'b0;
        bus.ball_w = 8'd8;
        bus.ball_h = 8'd8;
        bus.pad_l_y = 10'd200;
        bus.pad_r_y = 10'd200;
        place(320, 240);
        tick(0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick(0);
        // wall: hold while static, lockout while still touching the same wall
        place(300, 0);   tick(2);
        tick(2);
        place(301, 1);   tick(0);
        tick(0);
        place(301, 0);   tick(2);
        place(302, 0);   tick(0);
        place(303, 0);   tick(0);
        tick(0);
        place(303, 5);   tick(0);
        tick(0);
        // left paddle hits, speed saturation under speed-up
        for (int i = 0; i < 6; i++) begin
            place(24, 210); pad_hit(); tick(1);
            place(25, 210); tick(0);
            tick(0);
        end
        // left miss: right scores, speed re-served, back to PLAY directly
        place(0, 100); sr = 1; sp = 6; tick(3);
        tick(3);
        place(321, 0); tick(0);
        tick(2);
        place(322, 1); tick(0);
        tick(0);
        // right misses up to game over
        for (int i = 0; i < 8; i++) begin
            place(632, 100); sl++; tick(3);
            place(320, 240); tick(0);
        end
        place(632, 100); sl = 9; tick(3, 1);
        place(320, 240); tick(3, 1);
        place(330, 250); tick(3, 1);
        tick(3, 1);
        bus.restart = 1'b1; sl = 0; sr = 0; sp = 6; tick(0);
        bus.restart = 1'b0; tick(0);
        // restart mid-HOLD
        place(632, 100); sl = 1; tick(3);
        bus.restart = 1'b1; sl = 0; tick(0);
        bus.restart = 1'b0; sl = 1; tick(3);
        place(320, 240); tick(0);
        // corner: right paddle and bottom wall together
        bus.pad_r_y = 10'd420;
        place(610, 472); pad_hit(); tick(1);
        place(611, 472); tick(0);
        tick(0);
        tick(0);
        place(600, 472); tick(0);
        tick(2);
        tick(2);
        // reset during HOLD
        reset = 1'b1; sl = 0; sr = 0; sp = 6; tick(0);
        reset = 1'b0; place(320, 240); tick(0);
        tick(0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
